// File: rtl/button_event.sv
// button_event
//   Turns a debounced button level into press, release, long-press and
//   auto-repeat events. Every output is a register; nothing is combinational
//   from btn_debounced.
//
//   Parameters
//     LONG_PRESS_TIME : edges from the press edge until a hold counts as long (>= 2)
//     REPEAT_PERIOD   : edges between auto-repeat pulses while long-held (>= 1)
//
//   Ports
//     clk           : system clock, rising edge
//     rst           : asynchronous active-high reset
//     btn_debounced : clean button level, 1 = pressed
//     press_pulse   : one-cycle pulse after a press
//     release_pulse : one-cycle pulse after a release
//     long_pulse    : one-cycle pulse when the hold becomes long
//     repeat_pulse  : one-cycle auto-repeat pulse during a long hold
//     long_held     : high while in the long-hold state
//
//   Configuration
//     BUTTON_EVENT_REPEAT_EN : when defined, the repeat counter and
//     repeat_pulse generation are built; otherwise repeat_pulse is tied to 0.
module button_event #(
    parameter int LONG_PRESS_TIME = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic long_held
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    // Counter starts at 0 on the press edge, so the threshold edge sees
    // LONG_PRESS_TIME-1 in the register.
    localparam logic [31:0] LONG_LAST = 32'(LONG_PRESS_TIME - 1);

    state_t      state_q, state_d;
    logic        btn_prev_q;
    logic [31:0] hold_q, hold_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic        long_held_q, long_held_d;
    logic        rise, fall;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [31:0] REP_LAST = 32'(REPEAT_PERIOD - 1);
    logic [31:0] rep_q, rep_d;
    logic        repeat_q, repeat_d;
`else
    logic [31:0] rep_period_unused;
    assign rep_period_unused = 32'(REPEAT_PERIOD);
`endif

    assign rise = btn_debounced & ~btn_prev_q;
    assign fall = ~btn_debounced & btn_prev_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        rep_d     = rep_q;
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                // Release wins over a coincident long threshold.
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                    rep_d     = '0;
`endif
                end else if (btn_debounced) begin
                    if (hold_q != '1) begin
                        hold_d = hold_q + 32'd1;
                    end
                    if (hold_q == LONG_LAST) begin
                        state_d = LONG;
                        long_d  = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
                end
            end
            LONG: begin
                // Release wins over a coincident repeat edge.
                if (fall) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                    rep_d     = '0;
`endif
                end else if (btn_debounced) begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (rep_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + 32'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        long_held_d = (state_d == LONG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            btn_prev_q  <= 1'b0;
            hold_q      <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            long_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_debounced;
            hold_q      <= hold_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            long_held_q <= long_held_d;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            repeat_q <= repeat_d;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign long_held     = long_held_q;

endmodule
